ram_1p_arb2: RTL and testbench

- Parametrised single-port synchronous RAM shared by two requesters (port A, port B), e.g. instruction fetch and LSU.
- A round-robin arbiter decides which port accesses the array each cycle. Each port gets its own grant, response-valid and read-data signals.
- Generalises the existing single-port RAM in three ways: width and depth are parameters; all byte lanes enabled in the byte-enable are written; a per-port req/gnt handshake is added.
- Sits between the core bus ports and the memory array.

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 38 +++
 rtl/ram_1p_arb2.sv | 178 +++++++++++++++++
 tb/tb_ram_1p_arb2.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types, default geometry and the byte-parity helper for the
// two-port arbitrated single-port RAM.
package ram_arb_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefDepth = 256;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic parity_byte(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Only contested cycles move the priority
// state; the side that lost the last conflict wins the next one.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic r_last_b;
    logic w_contested;

    assign w_contested = req[0] & req[1];

    // Grant decode; nothing is granted while reset is held.
    always_comb begin
        gnt = 2'b00;
        if (!rst_ni) begin
            gnt = 2'b00;
        end else if (w_contested) begin
            gnt = r_last_b ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Priority state: remembers whether B won the last conflict.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_last_b <= 1'b1;
        end else if (w_contested) begin
            r_last_b <= gnt[1];
        end else begin
            r_last_b <= r_last_b;
        end
    end

endmodule

// File: rtl/ram_1p_arb2.sv
// Single-port byte-lane RAM shared by two requesters via rr_arb2, read-first.
// Optional per-lane even parity is enabled with `define RAM_1P_ARB2_PARITY_EN.
module ram_1p_arb2
    import ram_arb_pkg::*;
#(
    parameter int unsigned Width = DefWidth,
    parameter int unsigned Depth = DefDepth
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             a_req_i,
    output logic             a_gnt_o,
    input  logic             a_we_i,
    input  logic [Width/8-1:0] a_be_i,
    input  logic [31:0]      a_addr_i,
    input  logic [Width-1:0] a_wdata_i,
    output logic             a_rvalid_o,
    output logic [Width-1:0] a_rdata_o,
    output logic             a_rerr_o,

    input  logic             b_req_i,
    output logic             b_gnt_o,
    input  logic             b_we_i,
    input  logic [Width/8-1:0] b_be_i,
    input  logic [31:0]      b_addr_i,
    input  logic [Width-1:0] b_wdata_i,
    output logic             b_rvalid_o,
    output logic [Width-1:0] b_rdata_o,
    output logic             b_rerr_o
);

    localparam int unsigned Aw = $clog2(Depth);
    localparam int unsigned Bw = Width / 8;
    localparam int unsigned Ow = $clog2(Bw);

    logic [1:0]       w_gnt;
    logic             w_access;
    port_sel_e        w_sel;
    logic             w_we;
    logic [Bw-1:0]    w_be;
    logic [31:0]      w_addr;
    logic [Width-1:0] w_wdata;
    logic [Aw-1:0]    w_idx;
    logic [Width-1:0] w_rd_word;
    logic [31:0]      w_unused_addr;

    logic [Width-1:0] r_mem [Depth];

    logic             r_a_rvalid;
    logic [Width-1:0] r_a_rdata;
    logic             r_b_rvalid;
    logic [Width-1:0] r_b_rdata;

    rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    ({b_req_i, a_req_i}),
        .gnt    (w_gnt)
    );

    assign a_gnt_o  = w_gnt[0];
    assign b_gnt_o  = w_gnt[1];
    assign w_access = |w_gnt;

    // Steer the granted port's request onto the single array port.
    always_comb begin
        w_sel   = PORT_A;
        w_we    = a_we_i;
        w_be    = a_be_i;
        w_addr  = a_addr_i;
        w_wdata = a_wdata_i;
        if (w_gnt[1]) begin
            w_sel = PORT_B;
        end else begin
            w_sel = PORT_A;
        end
        if (w_sel == PORT_B) begin
            w_we    = b_we_i;
            w_be    = b_be_i;
            w_addr  = b_addr_i;
            w_wdata = b_wdata_i;
        end else begin
            w_we    = a_we_i;
            w_be    = a_be_i;
            w_addr  = a_addr_i;
            w_wdata = a_wdata_i;
        end
    end

    // Upper and byte-offset address bits alias; they are deliberately dropped.
    assign w_idx         = w_addr[Aw+Ow-1:Ow];
    assign w_unused_addr = a_addr_i ^ b_addr_i;
    assign w_rd_word     = r_mem[w_idx];

    // Byte-lane write into the array; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (w_access && w_we) begin
            for (int i = 0; i < int'(Bw); i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Per-port response registers; read data is captured before the write lands.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_a_rvalid <= 1'b0;
            r_a_rdata  <= {Width{1'b0}};
            r_b_rvalid <= 1'b0;
            r_b_rdata  <= {Width{1'b0}};
        end else begin
            r_a_rvalid <= w_gnt[0];
            r_b_rvalid <= w_gnt[1];
            if (w_gnt[0]) begin
                r_a_rdata <= w_rd_word;
            end
            if (w_gnt[1]) begin
                r_b_rdata <= w_rd_word;
            end
        end
    end

    // A response due in a cycle where reset is asserted is dropped.
    assign a_rvalid_o = r_a_rvalid & rst_ni;
    assign b_rvalid_o = r_b_rvalid & rst_ni;
    assign a_rdata_o  = r_a_rdata;
    assign b_rdata_o  = r_b_rdata;

`ifdef RAM_1P_ARB2_PARITY_EN
    logic [Bw-1:0] r_par [Depth];
    logic [Bw-1:0] w_calc_par;
    logic          w_rd_err;
    logic          r_a_rerr;
    logic          r_b_rerr;

    // Parity bits follow the same lane enables as the data.
    always_ff @(posedge clk_i) begin
        if (w_access && w_we) begin
            for (int i = 0; i < int'(Bw); i++) begin
                if (w_be[i]) begin
                    r_par[w_idx][i] <= parity_byte(w_wdata[8*i +: 8]);
                end
            end
        end
    end

    // Recompute lane parity of the word being read.
    always_comb begin
        w_calc_par = {Bw{1'b0}};
        for (int i = 0; i < int'(Bw); i++) begin
            w_calc_par[i] = parity_byte(w_rd_word[8*i +: 8]);
        end
    end

    assign w_rd_err = |(w_calc_par ^ r_par[w_idx]);

    // Error flag lives only in the response cycle of the owning port.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_a_rerr <= 1'b0;
            r_b_rerr <= 1'b0;
        end else begin
            r_a_rerr <= w_gnt[0] & w_rd_err;
            r_b_rerr <= w_gnt[1] & w_rd_err;
        end
    end

    assign a_rerr_o = r_a_rerr & rst_ni;
    assign b_rerr_o = r_b_rerr & rst_ni;
`else
    assign a_rerr_o = 1'b0;
    assign b_rerr_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_1p_arb2.sv
// Directed table-driven bench for ram_1p_arb2 plus hand-written reset and
// parity sequences.
module tb_ram_1p_arb2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        a_req_i, a_gnt_o, a_we_i, a_rvalid_o, a_rerr_o;
    logic [3:0]  a_be_i;
    logic [31:0] a_addr_i, a_wdata_i, a_rdata_o;
    logic        b_req_i, b_gnt_o, b_we_i, b_rvalid_o, b_rerr_o;
    logic [3:0]  b_be_i;
    logic [31:0] b_addr_i, b_wdata_i, b_rdata_o;

    always #5 clk_i = ~clk_i;

    ram_1p_arb2 #(.Width(32), .Depth(256)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .a_req_i    (a_req_i),
        .a_gnt_o    (a_gnt_o),
        .a_we_i     (a_we_i),
        .a_be_i     (a_be_i),
        .a_addr_i   (a_addr_i),
        .a_wdata_i  (a_wdata_i),
        .a_rvalid_o (a_rvalid_o),
        .a_rdata_o  (a_rdata_o),
        .a_rerr_o   (a_rerr_o),
        .b_req_i    (b_req_i),
        .b_gnt_o    (b_gnt_o),
        .b_we_i     (b_we_i),
        .b_be_i     (b_be_i),
        .b_addr_i   (b_addr_i),
        .b_wdata_i  (b_wdata_i),
        .b_rvalid_o (b_rvalid_o),
        .b_rdata_o  (b_rdata_o),
        .b_rerr_o   (b_rerr_o)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    // exp_gv = {a_gnt, b_gnt, a_rvalid, b_rvalid} observed in the same cycle.
    typedef struct {
        op_t         a;
        op_t         b;
        logic [3:0]  exp_gv;
        logic        ca;
        logic [31:0] da;
        logic        cb;
        logic [31:0] db;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs [23];

    function automatic op_t nop();
        op_t o;
        o.req = 1'b0; o.we = 1'b0; o.be = 4'h0; o.addr = 32'h0; o.wdata = 32'h0;
        return o;
    endfunction

    function automatic op_t rd(input logic [31:0] addr);
        op_t o;
        o.req = 1'b1; o.we = 1'b0; o.be = 4'h0; o.addr = addr; o.wdata = 32'h0;
        return o;
    endfunction

    function automatic op_t wr(input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] data);
        op_t o;
        o.req = 1'b1; o.we = 1'b1; o.be = be; o.addr = addr; o.wdata = data;
        return o;
    endfunction

    function automatic vec_t mkv(input op_t a, input op_t b, input logic [3:0] gv,
                                 input logic ca, input logic [31:0] da,
                                 input logic cb, input logic [31:0] db);
        vec_t v;
        v.a = a; v.b = b; v.exp_gv = gv; v.ca = ca; v.da = da; v.cb = cb; v.db = db;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input op_t a, input op_t b);
        a_req_i = a.req; a_we_i = a.we; a_be_i = a.be; a_addr_i = a.addr; a_wdata_i = a.wdata;
        b_req_i = b.req; b_we_i = b.we; b_be_i = b.be; b_addr_i = b.addr; b_wdata_i = b.wdata;
    endtask

    initial begin
        vecs[0]  = mkv(nop(), nop(), 4'b0000, 1'b1, 32'h0, 1'b1, 32'h0);
        vecs[1]  = mkv(wr(32'h10, 4'hF, 32'hDEADBEEF), nop(), 4'b1000, 1'b1, 32'h0, 1'b1, 32'h0);
        vecs[2]  = mkv(rd(32'h10), nop(), 4'b1010, 1'b0, 32'h0, 1'b1, 32'h0);
        vecs[3]  = mkv(wr(32'h20, 4'hF, 32'h0), nop(), 4'b1010, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0);
        vecs[4]  = mkv(wr(32'h20, 4'b0101, 32'hAABBCCDD), nop(), 4'b1010, 1'b0, 32'h0, 1'b1, 32'h0);
        vecs[5]  = mkv(rd(32'h20), nop(), 4'b1010, 1'b1, 32'h0, 1'b1, 32'h0);
        vecs[6]  = mkv(wr(32'h40, 4'hF, 32'h11111111), nop(), 4'b1010, 1'b1, 32'h00BB00DD, 1'b1, 32'h0);
        vecs[7]  = mkv(nop(), wr(32'h40, 4'hF, 32'h12345678), 4'b0110, 1'b0, 32'h0, 1'b1, 32'h0);
        vecs[8]  = mkv(rd(32'h40), nop(), 4'b1001, 1'b0, 32'h0, 1'b1, 32'h11111111);
        vecs[9]  = mkv(nop(), nop(), 4'b0010, 1'b1, 32'h12345678, 1'b1, 32'h11111111);
        vecs[10] = mkv(rd(32'h10), rd(32'h20), 4'b1000, 1'b1, 32'h12345678, 1'b1, 32'h11111111);
        vecs[11] = mkv(rd(32'h10), rd(32'h20), 4'b0110, 1'b1, 32'hDEADBEEF, 1'b1, 32'h11111111);
        vecs[12] = mkv(rd(32'h10), rd(32'h20), 4'b1001, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00BB00DD);
        vecs[13] = mkv(rd(32'h10), rd(32'h20), 4'b0110, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00BB00DD);
        vecs[14] = mkv(rd(32'h10), rd(32'h20), 4'b1001, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00BB00DD);
        vecs[15] = mkv(rd(32'h10), rd(32'h20), 4'b0110, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00BB00DD);
        vecs[16] = mkv(rd(32'h40), nop(), 4'b1001, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00BB00DD);
        vecs[17] = mkv(rd(32'h20), rd(32'h10), 4'b1010, 1'b1, 32'h12345678, 1'b1, 32'h00BB00DD);
        vecs[18] = mkv(nop(), nop(), 4'b0010, 1'b1, 32'h00BB00DD, 1'b1, 32'h00BB00DD);
        vecs[19] = mkv(rd(32'hFFFFFC13), nop(), 4'b1000, 1'b1, 32'h00BB00DD, 1'b1, 32'h00BB00DD);
        vecs[20] = mkv(wr(32'h10, 4'h0, 32'h0), nop(), 4'b1010, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00BB00DD);
        vecs[21] = mkv(rd(32'h10), nop(), 4'b1010, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00BB00DD);
        vecs[22] = mkv(nop(), nop(), 4'b0010, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00BB00DD);

        // Reset with both ports requesting: nothing may be granted.
        rst_ni = 1'b0;
        drive(rd(32'h0), rd(32'h4));
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst a_gnt", {31'h0, a_gnt_o}, 32'h0);
        chk("rst b_gnt", {31'h0, b_gnt_o}, 32'h0);
        chk("rst a_rvalid", {31'h0, a_rvalid_o}, 32'h0);
        chk("rst b_rvalid", {31'h0, b_rvalid_o}, 32'h0);
        chk("rst a_rdata", a_rdata_o, 32'h0);
        chk("rst b_rdata", b_rdata_o, 32'h0);
        chk("rst a_rerr", {31'h0, a_rerr_o}, 32'h0);
        rst_ni = 1'b1;
        drive(nop(), nop());
        @(negedge clk_i);

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("v%0d a_gnt", i), {31'h0, a_gnt_o}, {31'h0, vecs[i].exp_gv[3]});
            chk($sformatf("v%0d b_gnt", i), {31'h0, b_gnt_o}, {31'h0, vecs[i].exp_gv[2]});
            chk($sformatf("v%0d a_rvalid", i), {31'h0, a_rvalid_o}, {31'h0, vecs[i].exp_gv[1]});
            chk($sformatf("v%0d b_rvalid", i), {31'h0, b_rvalid_o}, {31'h0, vecs[i].exp_gv[0]});
            if (vecs[i].ca) begin
                chk($sformatf("v%0d a_rdata", i), a_rdata_o, vecs[i].da);
                chk($sformatf("v%0d a_rerr", i), {31'h0, a_rerr_o}, 32'h0);
            end
            if (vecs[i].cb) begin
                chk($sformatf("v%0d b_rdata", i), b_rdata_o, vecs[i].db);
                chk($sformatf("v%0d b_rerr", i), {31'h0, b_rerr_o}, 32'h0);
            end
            @(negedge clk_i);
        end

        // Reset right after a granted write: response dropped, write kept.
        drive(wr(32'h50, 4'hF, 32'hCAFEF00D), nop());
        #1;
        chk("rstg a_gnt", {31'h0, a_gnt_o}, 32'h1);
        @(negedge clk_i);
        drive(nop(), nop());
        rst_ni = 1'b0;
        #1;
        chk("rstg a_rvalid", {31'h0, a_rvalid_o}, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(rd(32'h50), nop());
        #1;
        chk("rstg rd gnt", {31'h0, a_gnt_o}, 32'h1);
        @(negedge clk_i);
        drive(rd(32'h10), rd(32'h20));
        #1;
        chk("rstg rd rvalid", {31'h0, a_rvalid_o}, 32'h1);
        chk("rstg rd data", a_rdata_o, 32'hCAFEF00D);
        // Priority state is back to A-first after reset.
        chk("rstg prio a_gnt", {31'h0, a_gnt_o}, 32'h1);
        chk("rstg prio b_gnt", {31'h0, b_gnt_o}, 32'h0);
        @(negedge clk_i);

        // Parity: clean read, then (when built in) a corrupted one.
        drive(wr(32'h60, 4'hF, 32'h000000FF), nop());
        @(negedge clk_i);
        drive(rd(32'h60), nop());
        @(negedge clk_i);
        drive(nop(), nop());
        #1;
        chk("par clean rvalid", {31'h0, a_rvalid_o}, 32'h1);
        chk("par clean data", a_rdata_o, 32'h000000FF);
        chk("par clean rerr", {31'h0, a_rerr_o}, 32'h0);
`ifdef RAM_1P_ARB2_PARITY_EN
        dut.r_mem[24][0] = ~dut.r_mem[24][0];
        drive(rd(32'h60), nop());
        @(negedge clk_i);
        drive(nop(), nop());
        #1;
        chk("par bad rvalid", {31'h0, a_rvalid_o}, 32'h1);
        chk("par bad data", a_rdata_o, 32'h000000FE);
        chk("par bad rerr", {31'h0, a_rerr_o}, 32'h1);
`endif
        @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
